// File: rtl/spram_port_arbiter.sv
// spram_port_arbiter: shares one single-port image SPRAM between the buffered
// UART pixel-write path and the VGA pixel-fetch path. Reads win arbitration;
// when the write buffer is full and reads have monopolised the port for
// STARVE_LIMIT grants, one write is forced through.
module spram_port_arbiter #(
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned DATA_W       = 12,
   parameter int unsigned WFIFO_DEPTH  = 4,
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         wr_req,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         wr_ready,
   input  logic                         rd_req,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic                         rd_ready,
   output logic                         rd_valid,
   output logic [DATA_W-1:0]            rd_data,
   output logic [ADDR_W-1:0]            spram_addr,
   output logic [DATA_W-1:0]            spram_wr_data,
   output logic                         spram_wre,
   input  logic [DATA_W-1:0]            spram_rd_data,
   output logic [$clog2(WFIFO_DEPTH):0] wfifo_level
);

   localparam int unsigned PTR_W    = $clog2(WFIFO_DEPTH);
   localparam int unsigned LVL_W    = PTR_W + 1;
   localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);

   logic [ADDR_W-1:0]   fifo_addr [WFIFO_DEPTH];
   logic [DATA_W-1:0]   fifo_data [WFIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [STREAK_W-1:0] rd_streak;
   logic [RD_LAT-1:0]   rd_pipe;

   logic fifo_full;
   logic fifo_empty;
   logic force_wr;
   logic grant_rd;
   logic grant_wr;
   logic push;

   // Arbitration and handshakes, all derived from registered state plus requests
   always_comb begin
      fifo_full  = (wfifo_level == LVL_W'(WFIFO_DEPTH));
      fifo_empty = (wfifo_level == '0);
      force_wr   = fifo_full && (rd_streak >= STREAK_W'(STARVE_LIMIT));
      grant_rd   = !rst && rd_req && !force_wr;
      grant_wr   = !rst && !grant_rd && !fifo_empty;
      rd_ready   = grant_rd;
      wr_ready   = !rst && !fifo_full;
      push       = wr_req && wr_ready && !flush;
   end

   // Write buffer storage; contents are don't-care until counted by the level
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= wr_addr;
         fifo_data[wr_ptr] <= wr_data;
      end
   end

   // Write buffer pointers and occupancy; flush discards everything buffered
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         wfifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (grant_wr) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !grant_wr) begin
            wfifo_level <= wfifo_level + LVL_W'(1);
         end else if (grant_wr && !push) begin
            wfifo_level <= wfifo_level - LVL_W'(1);
         end
      end
   end

   // Count reads that bypass a waiting write; any write or an empty buffer resets it
   always_ff @(posedge clk) begin
      if (rst || flush || fifo_empty || grant_wr) begin
         rd_streak <= '0;
      end else if (grant_rd && (rd_streak < STREAK_W'(STARVE_LIMIT))) begin
         rd_streak <= rd_streak + STREAK_W'(1);
      end
   end

   // Registered SPRAM drive: a grant this cycle owns the port next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         spram_addr    <= '0;
         spram_wr_data <= '0;
         spram_wre     <= 1'b0;
      end else if (grant_rd) begin
         spram_addr <= rd_addr;
         spram_wre  <= 1'b0;
      end else if (grant_wr) begin
         spram_addr    <= fifo_addr[rd_ptr];
         spram_wr_data <= fifo_data[rd_ptr];
         spram_wre     <= 1'b1;
      end else begin
         spram_wre <= 1'b0;
      end
   end

   // Read-return pipeline; reset kills any read still in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pipe  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_pipe[0] <= grant_rd;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
         rd_valid <= rd_pipe[RD_LAT-1];
         if (rd_pipe[RD_LAT-1]) begin
            rd_data <= spram_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Bench for spram_port_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based model of the arbiter.
module tb_spram_port_arbiter;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DATA_W = 12;
   localparam int          DEPTH  = 4;
   localparam int          RD_LAT = 1;
   localparam int          LIMIT  = 8;
   localparam int          MEM_N  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst, flush, wr_req, rd_req;
   logic [ADDR_W-1:0] wr_addr, rd_addr, spram_addr;
   logic [DATA_W-1:0] wr_data, rd_data, spram_wr_data, spram_rd_data;
   logic              wr_ready, rd_ready, rd_valid, spram_wre;
   logic [2:0]        wfifo_level;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
   typedef struct { int due; logic [DATA_W-1:0] d; } rd_t;

   // Model state: buffered writes, reads in flight, expected memory image
   wr_t               wq[$];
   rd_t               rq[$];
   logic [DATA_W-1:0] mem  [0:MEM_N-1];
   logic [DATA_W-1:0] xmem [0:MEM_N-1];
   int                streak;
   logic [ADDR_W-1:0] x_addr;
   logic [DATA_W-1:0] x_wdata, x_rdata;
   logic              x_wre, x_rvalid;
   bit                m_rd_acc, m_wr_acc;

   int wi, lows, first_low, acc_before_full, pulses, rd_pct;

   always #5 clk = ~clk;

   spram_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WFIFO_DEPTH(DEPTH),
      .RD_LAT(RD_LAT), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .spram_addr(spram_addr), .spram_wr_data(spram_wr_data), .spram_wre(spram_wre),
      .spram_rd_data(spram_rd_data), .wfifo_level(wfifo_level)
   );

   function automatic logic [DATA_W-1:0] pix(int i);
      return DATA_W'(i * 7 + 3);
   endfunction

   // SPRAM stand-in: data follows the address in the same cycle, writes at the edge
   initial begin
      for (int i = 0; i < MEM_N; i++) mem[i] = pix(i);
      mem[15'h1234] = 12'hABC;
      forever begin
         @(posedge clk);
         if (spram_wre) mem[spram_addr] <= spram_wr_data;
      end
   end
   assign spram_rd_data = mem[spram_addr];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // Called at a falling edge with inputs set: compare, advance model, move one cycle
   task automatic step();
      bit  full, force_w, g_rd, g_wr, was_empty, push;
      wr_t h;
      rd_t r;
      #1;
      full      = (wq.size() == DEPTH);
      force_w   = full && (streak >= LIMIT);
      g_rd      = !rst && rd_req && !force_w;
      g_wr      = !rst && !g_rd && (wq.size() != 0);
      was_empty = (wq.size() == 0);
      push      = !rst && wr_req && !full && !flush;

      chk("wr_ready", wr_ready, !rst && !full);
      chk("rd_ready", rd_ready, g_rd);
      chk("wfifo_level", wfifo_level, wq.size());
      chk("spram_wre", spram_wre, x_wre);
      chk("spram_addr", spram_addr, x_addr);
      chk("spram_wr_data", spram_wr_data, x_wdata);
      chk("rd_valid", rd_valid, x_rvalid);
      chk("rd_data", rd_data, x_rdata);

      m_rd_acc = g_rd;
      m_wr_acc = push;

      if (rst) begin
         wq.delete();
         rq.delete();
         streak   = 0;
         x_addr   = '0;
         x_wdata  = '0;
         x_wre    = 1'b0;
         x_rvalid = 1'b0;
         x_rdata  = '0;
      end else begin
         if (g_rd) begin
            x_addr = rd_addr;
            x_wre  = 1'b0;
         end else if (g_wr) begin
            h       = wq.pop_front();
            x_addr  = h.a;
            x_wdata = h.d;
            x_wre   = 1'b1;
            xmem[h.a] = h.d;
         end else begin
            x_wre = 1'b0;
         end
         x_rvalid = 1'b0;
         if (rq.size() != 0 && rq[0].due == cyc + 1) begin
            r        = rq.pop_front();
            x_rvalid = 1'b1;
            x_rdata  = r.d;
         end
         if (g_rd) rq.push_back('{due: cyc + 1 + RD_LAT, d: xmem[rd_addr]});
         if (flush || was_empty || g_wr) streak = 0;
         else if (g_rd && streak < LIMIT) streak++;
         if (push) wq.push_back('{a: wr_addr, d: wr_data});
         if (flush) wq.delete();
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < MEM_N; i++) xmem[i] = pix(i);
      xmem[15'h1234] = 12'hABC;
      streak = 0; x_addr = '0; x_wdata = '0; x_rdata = '0; x_wre = 1'b0; x_rvalid = 1'b0;
      m_rd_acc = 1'b0; m_wr_acc = 1'b0;
      rst = 1'b1; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; wr_data = '0; rd_addr = '0;
      @(negedge clk);
      step();
      step();

      // Reset released, idle
      rst = 1'b0;
      #1;
      chk("t1_wr_ready", wr_ready, 1);
      chk("t1_level", wfifo_level, 0);
      chk("t1_rd_valid", rd_valid, 0);
      step();
      step();
      chk("t1_wre", spram_wre, 0);

      // Writes only: each lands two cycles after acceptance
      for (int i = 0; i < 8; i++) begin
         wr_req  = (i < 5);
         wr_addr = ADDR_W'(i);
         wr_data = DATA_W'(12'hF00 + i);
         #1;
         chk("t2_level_le1", (wfifo_level <= 3'd1), 1);
         if (i >= 2 && i < 7) begin
            chk("t2_wre", spram_wre, 1);
            chk("t2_addr", spram_addr, i - 2);
            chk("t2_data", spram_wr_data, 12'hF00 + i - 2);
         end else if (i == 7) begin
            chk("t2_wre_end", spram_wre, 0);
         end
         step();
      end
      wr_req = 1'b0;
      step();

      // Single read latency
      rd_req = 1'b1; rd_addr = 15'h1234;
      step();
      rd_req = 1'b0;
      #1;
      chk("t3_addr", spram_addr, 15'h1234);
      chk("t3_valid_n1", rd_valid, 0);
      step();
      #1;
      chk("t3_valid_n2", rd_valid, 1);
      chk("t3_data", rd_data, 12'hABC);
      step();
      #1;
      chk("t3_valid_n3", rd_valid, 0);
      step();

      // Contention: continuous reads with six writes queued behind them
      wi = 0; lows = 0; first_low = -1; acc_before_full = -1;
      rd_req = 1'b1; rd_addr = 15'h0100;
      for (int c = 0; c < 36; c++) begin
         wr_req  = (wi < 6);
         wr_addr = ADDR_W'(16'h0200 + wi);
         wr_data = DATA_W'(12'hE00 + wi);
         #1;
         if (!rd_ready) begin
            lows++;
            if (first_low < 0) first_low = c;
         end
         if (!wr_ready && acc_before_full < 0) acc_before_full = wi;
         step();
         if (m_wr_acc) wi++;
      end
      chk("t4_forced_cycles", lows, 3);
      chk("t4_first_forced", first_low, 9);
      chk("t4_accepted_before_full", acc_before_full, 4);
      rd_req = 1'b0; wr_req = 1'b0;
      for (int c = 0; c < 8; c++) step();
      chk("t4_drained", wfifo_level, 0);
      for (int k = 0; k < 6; k++) chk("t4_landed", mem[16'h0200 + k], 12'hE00 + k);

      // Simultaneous read and push with two entries buffered
      rd_req = 1'b1; rd_addr = 15'h0300;
      for (int c = 0; c < 2; c++) begin
         wr_req = 1'b1; wr_addr = ADDR_W'(16'h0400 + c); wr_data = DATA_W'(12'hD00 + c);
         step();
      end
      wr_req = 1'b1; wr_addr = 15'h0402; wr_data = 12'hD02;
      #1;
      chk("t5_level2", wfifo_level, 2);
      chk("t5_rd_ready", rd_ready, 1);
      chk("t5_wr_ready", wr_ready, 1);
      step();
      wr_req = 1'b0;
      #1;
      chk("t5_level3", wfifo_level, 3);
      step();
      #1;
      chk("t5_level_hold", wfifo_level, 3);
      chk("t5_no_wre", spram_wre, 0);
      step();
      rd_req = 1'b0;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         pulses += int'(spram_wre);
      end
      chk("t5_drain_pulses", pulses, 3);

      // Flush with three entries buffered
      rd_req = 1'b1; rd_addr = 15'h0301;
      for (int c = 0; c < 3; c++) begin
         wr_req = 1'b1; wr_addr = ADDR_W'(16'h0500 + c); wr_data = DATA_W'(12'hC00 + c);
         step();
      end
      wr_req = 1'b0; flush = 1'b1;
      #1;
      chk("t6_level3", wfifo_level, 3);
      step();
      flush = 1'b0; rd_req = 1'b0;
      #1;
      chk("t6_level0", wfifo_level, 0);
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         pulses += int'(spram_wre);
      end
      chk("t6_no_wre", pulses, 0);

      // Reset while a read is in flight
      rd_req = 1'b1; rd_addr = 15'h0302;
      step();
      rd_req = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("t6_rst_no_valid", rd_valid, 0);
      step();
      chk("t6_rst_no_valid2", rd_valid, 0);

      // Randomized traffic; requesters hold until accepted
      for (int c = 0; c < 4000; c++) begin
         rd_pct = ((c / 500) % 2 == 1) ? 95 : 40;
         if (!(rd_req && !m_rd_acc)) begin
            rd_req  = ($urandom_range(99) < rd_pct);
            rd_addr = ADDR_W'($urandom_range(31));
         end
         if (!(wr_req && !m_wr_acc)) begin
            wr_req  = ($urandom_range(99) < 50);
            wr_addr = ADDR_W'($urandom_range(31));
            wr_data = DATA_W'($urandom);
         end
         flush = ($urandom_range(99) < 2);
         rst   = ($urandom_range(999) < 5);
         step();
      end
      rst = 1'b0; flush = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      for (int c = 0; c < 10; c++) step();
      chk("final_level", wfifo_level, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
